display_arbiter: RTL and testbench

Shares the single 4-digit seven-segment display between up to `N_REQ` requesters. Each requester presents a 16-bit value and a request. The arbiter grants the display round-robin and holds the granted value for a fixed dwell time. It drives the `num` input of the display driver plus a blank flag. It sits between the lab's producer blocks (counters, ALU results, status words) and the display driver.

---
 rtl/disp_pkg.sv | 13 +
 rtl/display_arbiter_rr_pick.sv | 37 +++
 rtl/display_arbiter.sv | 122 ++++++++++++
 tb/tb_display_arbiter.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
// Shared types and constants for the seven-segment display arbiter.
package disp_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SHOW = 1'b1
  } state_e;

  localparam int DISP_W  = 16;
  localparam int OWNER_W = 3;
  localparam logic [DISP_W-1:0] BLANK_NUM = 16'h0000;

endpackage

// File: rtl/display_arbiter_rr_pick.sv
// Round-robin search: nearest requester after last_i, wrapping mod N_REQ.
module rr_pick
  import disp_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]   req_i,
  input  logic [OWNER_W-1:0] last_i,
  output logic               found_o,
  output logic [OWNER_W-1:0] idx_o
);

  logic [2*N_REQ-1:0] dbl_s;
  logic [2*N_REQ-1:0] rot_s;
  int                 off_s;

  // Rotating a doubled copy puts requester (last_i+1) mod N_REQ at bit 0.
  assign dbl_s = {req_i, req_i};
  assign rot_s = dbl_s >> (int'(last_i) + 1);

  // Lowest set bit of the rotated vector is the nearest requester.
  always_comb begin
    off_s   = 0;
    found_o = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot_s[i]) begin
        off_s   = i;
        found_o = 1'b1;
      end else begin
        off_s   = off_s;
        found_o = found_o;
      end
    end
    idx_o = OWNER_W'((int'(last_i) + 1 + off_s) % N_REQ);
  end

endmodule

// File: rtl/display_arbiter.sv
// Round-robin owner of the shared 4-digit display; holds each granted value for DWELL cycles.
module display_arbiter
  import disp_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int DWELL = 50_000_000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req_i,
  input  logic [DISP_W*N_REQ-1:0]   data_i,
  output logic [N_REQ-1:0]          grant_o,
  output logic [N_REQ-1:0]          done_o,
  output logic [DISP_W-1:0]         disp_num_o,
  output logic                      disp_blank_o,
  output logic [OWNER_W-1:0]        owner_o
);

  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0]   CNT_LOAD = CNT_W'(DWELL - 1);
  localparam logic [N_REQ-1:0]   ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};
  localparam logic [OWNER_W-1:0] OWNER_RST = OWNER_W'(N_REQ - 1);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [N_REQ-1:0]     grant_q, grant_d;
  logic [N_REQ-1:0]     done_q, done_d;
  logic [DISP_W-1:0]    num_q, num_d;
  logic                 blank_q, blank_d;
  logic [OWNER_W-1:0]   owner_q, owner_d;

  logic                 found_s;
  logic [OWNER_W-1:0]   pick_s;
  logic                 own_req_s;
  logic [DISP_W*N_REQ-1:0] data_sh_s;

  rr_pick #(
    .N_REQ (N_REQ)
  ) u_rr_pick (
    .req_i   (req_i),
    .last_i  (owner_q),
    .found_o (found_s),
    .idx_o   (pick_s)
  );

  assign own_req_s = |(req_i & (ONE_HOT0 << owner_q));
  assign data_sh_s = data_i >> (DISP_W * int'(pick_s));

  // Next-state and next-output logic for the IDLE/SHOW machine.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    done_d  = {N_REQ{1'b0}};
    num_d   = num_q;
    blank_d = blank_q;
    owner_d = owner_q;
    case (state_q)
      IDLE: begin
        if (found_s) begin
          state_d = SHOW;
          grant_d = ONE_HOT0 << pick_s;
          num_d   = data_sh_s[DISP_W-1:0];
          owner_d = pick_s;
          blank_d = 1'b0;
          cnt_d   = CNT_LOAD;
        end else begin
          grant_d = {N_REQ{1'b0}};
          blank_d = 1'b1;
        end
      end
      SHOW: begin
        // Release wins over expiry: a dropped request never earns done.
        if (!own_req_s) begin
          state_d = IDLE;
          grant_d = {N_REQ{1'b0}};
          blank_d = 1'b1;
        end else if (cnt_q == {CNT_W{1'b0}}) begin
          state_d = IDLE;
          grant_d = {N_REQ{1'b0}};
          blank_d = 1'b1;
          done_d  = ONE_HOT0 << owner_q;
        end else begin
          cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = {N_REQ{1'b0}};
        blank_d = 1'b1;
      end
    endcase
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      grant_q <= {N_REQ{1'b0}};
      done_q  <= {N_REQ{1'b0}};
      num_q   <= BLANK_NUM;
      blank_q <= 1'b1;
      owner_q <= OWNER_RST;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      num_q   <= num_d;
      blank_q <= blank_d;
      owner_q <= owner_d;
    end
  end

  assign grant_o      = grant_q;
  assign done_o       = done_q;
  assign disp_num_o   = num_q;
  assign disp_blank_o = blank_q;
  assign owner_o      = owner_q;

endmodule

// File: tb/tb_display_arbiter.sv
// Scenario bench for display_arbiter (N_REQ=4, DWELL=4) with a queue of expected per-cycle outputs.
module tb_display_arbiter;

  localparam int N  = 4;
  localparam int DW = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [63:0] data;
  logic [3:0]  grant, done;
  logic [15:0] disp_num;
  logic        disp_blank;
  logic [2:0]  owner;

  typedef struct packed {
    logic [3:0]  g;
    logic [3:0]  d;
    logic [15:0] n;
    logic        b;
    logic [2:0]  o;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  display_arbiter #(.N_REQ(N), .DWELL(DW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_i        (req),
    .data_i       (data),
    .grant_o      (grant),
    .done_o       (done),
    .disp_num_o   (disp_num),
    .disp_blank_o (disp_blank),
    .owner_o      (owner)
  );

  function automatic exp_t mk(input logic [3:0] g, input logic [3:0] d,
                              input logic [15:0] n, input logic b, input logic [2:0] o);
    exp_t e;
    e.g = g; e.d = d; e.n = n; e.b = b; e.o = o;
    return e;
  endfunction

  function automatic exp_t obs();
    exp_t e;
    e.g = grant; e.d = done; e.n = disp_num; e.b = disp_blank; e.o = owner;
    return e;
  endfunction

  function automatic logic [15:0] slice(input int r);
    return data[r*16 +: 16];
  endfunction

  task automatic start_run(input logic [3:0] r, input logic [63:0] dv);
    rst_n = 1'b0;
    req   = r;
    data  = dv;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    exp_t e, o;
    int   order[5] = '{0, 1, 2, 3, 0};
    @(negedge clk);
    rst_n = 1'b0;
    req   = 4'b1111;
    data  = {16'hA333, 16'hA222, 16'hA111, 16'hA000};
    #1;
    o = obs();
    checks++;
    if (o !== mk(4'b0000, 4'b0000, 16'h0000, 1'b1, 3'd3)) begin
      errors++;
      $display("FAIL reset_state got %h exp g=0 d=0 n=0000 b=1 o=3", o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    foreach (order[t]) begin
      for (int c = 0; c < DW; c++)
        sb_q.push_back(mk(4'(1 << order[t]), 4'b0000, slice(order[t]), 1'b0, 3'(order[t])));
      sb_q.push_back(mk(4'b0000, 4'(1 << order[t]), slice(order[t]), 1'b1, 3'(order[t])));
    end
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      e = sb_q.pop_front();
      o = obs();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL rr_order cyc %0d got g=%b d=%b n=%h b=%b o=%0d exp g=%b d=%b n=%h b=%b o=%0d",
                 c, o.g, o.d, o.n, o.b, o.o, e.g, e.d, e.n, e.b, e.o);
      end
    end
  endtask

  task automatic test_single();
    exp_t e, o;
    start_run(4'b0100, {16'h0003, 16'hBEEF, 16'h0001, 16'h0000});
    for (int c = 0; c < DW; c++) sb_q.push_back(mk(4'b0100, 4'b0000, 16'hBEEF, 1'b0, 3'd2));
    sb_q.push_back(mk(4'b0000, 4'b0100, 16'hBEEF, 1'b1, 3'd2));
    for (int c = 0; c < DW; c++) sb_q.push_back(mk(4'b0100, 4'b0000, 16'hBEEF, 1'b0, 3'd2));
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      e = sb_q.pop_front();
      o = obs();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL single_req cyc %0d got g=%b d=%b n=%h b=%b o=%0d exp g=%b d=%b n=%h b=%b o=%0d",
                 c, o.g, o.d, o.n, o.b, o.o, e.g, e.d, e.n, e.b, e.o);
      end
    end
  endtask

  task automatic test_early_release();
    exp_t e, o;
    start_run(4'b0010, {16'h3333, 16'h2222, 16'h1111, 16'h0000});
    sb_q.push_back(mk(4'b0010, 4'b0000, 16'h1111, 1'b0, 3'd1));
    sb_q.push_back(mk(4'b0010, 4'b0000, 16'h1111, 1'b0, 3'd1));
    sb_q.push_back(mk(4'b0000, 4'b0000, 16'h1111, 1'b1, 3'd1));
    sb_q.push_back(mk(4'b1000, 4'b0000, 16'h3333, 1'b0, 3'd3));
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      e = sb_q.pop_front();
      o = obs();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL early_release cyc %0d got g=%b d=%b n=%h b=%b o=%0d exp g=%b d=%b n=%h b=%b o=%0d",
                 c, o.g, o.d, o.n, o.b, o.o, e.g, e.d, e.n, e.b, e.o);
      end
      if (c == 1) req = 4'b1000;
    end
    req = 4'b0000;
  endtask

  task automatic test_data_freeze();
    exp_t e, o;
    start_run(4'b0001, {16'h0000, 16'h0000, 16'h0000, 16'h1234});
    for (int c = 0; c < DW; c++) sb_q.push_back(mk(4'b0001, 4'b0000, 16'h1234, 1'b0, 3'd0));
    sb_q.push_back(mk(4'b0000, 4'b0001, 16'h1234, 1'b1, 3'd0));
    sb_q.push_back(mk(4'b0001, 4'b0000, 16'h5678, 1'b0, 3'd0));
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      e = sb_q.pop_front();
      o = obs();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL data_freeze cyc %0d got g=%b d=%b n=%h b=%b o=%0d exp g=%b d=%b n=%h b=%b o=%0d",
                 c, o.g, o.d, o.n, o.b, o.o, e.g, e.d, e.n, e.b, e.o);
      end
      if (c == 0) data[15:0] = 16'h5678;
    end
  endtask

  task automatic test_async_reset();
    exp_t e, o;
    start_run(4'b1111, {16'hD333, 16'hD222, 16'hD111, 16'hD000});
    sb_q.push_back(mk(4'b0001, 4'b0000, 16'hD000, 1'b0, 3'd0));
    sb_q.push_back(mk(4'b0001, 4'b0000, 16'hD000, 1'b0, 3'd0));
    sb_q.push_back(mk(4'b0000, 4'b0000, 16'h0000, 1'b1, 3'd3));
    sb_q.push_back(mk(4'b0001, 4'b0000, 16'hD000, 1'b0, 3'd0));
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      e = sb_q.pop_front();
      o = obs();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL async_pre cyc %0d got g=%b n=%h o=%0d exp g=%b n=%h o=%0d",
                 c, o.g, o.n, o.o, e.g, e.n, e.o);
      end
    end
    #2 rst_n = 1'b0;
    #1;
    e = sb_q.pop_front();
    o = obs();
    checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL async_reset got g=%b d=%b n=%h b=%b o=%0d exp g=%b d=%b n=%h b=%b o=%0d",
               o.g, o.d, o.n, o.b, o.o, e.g, e.d, e.n, e.b, e.o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    e = sb_q.pop_front();
    o = obs();
    checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL async_first got g=%b n=%h o=%0d exp g=%b n=%h o=%0d",
               o.g, o.n, o.o, e.g, e.n, e.o);
    end
  endtask

  task automatic test_idle();
    exp_t e, o;
    start_run(4'b0100, {16'h0000, 16'hCAFE, 16'h0000, 16'h0000});
    sb_q.push_back(mk(4'b0100, 4'b0000, 16'hCAFE, 1'b0, 3'd2));
    for (int c = 0; c < 11; c++) sb_q.push_back(mk(4'b0000, 4'b0000, 16'hCAFE, 1'b1, 3'd2));
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      e = sb_q.pop_front();
      o = obs();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL idle_hold cyc %0d got g=%b d=%b n=%h b=%b o=%0d exp g=%b d=%b n=%h b=%b o=%0d",
                 c, o.g, o.d, o.n, o.b, o.o, e.g, e.d, e.n, e.b, e.o);
      end
      if (c == 0) req = 4'b0000;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 4'b0000;
    data  = 64'h0;
    test_reset();
    test_single();
    test_early_release();
    test_data_freeze();
    test_async_reset();
    test_idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
